// File: rtl/conv5x5_window_relu.sv
// Streaming 5x5 valid-mode convolution over a 28x28 or 12x12 raster frame,
// followed by ReLU, arithmetic right-shift and saturation to 8 bits.
module conv5x5_window_relu #(
    parameter int MAX_W = 28,
    parameter int ACC_W = 24
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         state,
    input  logic         clear,
    input  logic         ivalid,
    input  logic [7:0]   din,
    input  logic [199:0] weights,
    input  logic [19:0]  bias,
    input  logic [4:0]   shift,
    output logic         ovalid,
    output logic [7:0]   dout,
    output logic         frame_done
);
    localparam int CW = $clog2(MAX_W);
    localparam logic [CW-1:0] LAST_BIG   = CW'(MAX_W - 1);
    localparam logic [CW-1:0] LAST_SMALL = CW'(11);
    localparam logic [CW-1:0] EDGE_MIN   = CW'(4);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] ZERO       = {CW{1'b0}};

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [16:0] p);
        return {{(ACC_W-17){p[16]}}, p};
    endfunction

    logic [CW-1:0] row_r;
    logic [CW-1:0] col_r;
    logic          st_r;
    logic          accept_s;
    logic          first_s;
    logic          st_sel_s;
    logic [CW-1:0] wmax_s;
    logic          launch_s;
    logic          last_pix_s;

    logic [7:0] lb_r  [0:3][0:MAX_W-1];
    logic [7:0] win_r [0:4][0:4];

    logic signed [16:0]      prod_s  [0:4][0:4];
    logic signed [16:0]      prod_r  [0:4][0:4];
    logic signed [ACC_W-1:0] rsum_s  [0:4];
    logic signed [ACC_W-1:0] rsum_r  [0:4];
    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] acc_r;
    logic        [ACC_W-1:0] shifted_s;
    logic        [7:0]       res_s;

    logic [3:0] v_r;
    logic [3:0] last_r;

    // Frame geometry; the mode is taken live on pixel (0,0) and from the latch afterwards.
    always_comb begin
        accept_s   = ivalid & ~clear;
        first_s    = (row_r == ZERO) && (col_r == ZERO);
        st_sel_s   = first_s ? state : st_r;
        wmax_s     = st_sel_s ? LAST_SMALL : LAST_BIG;
        launch_s   = accept_s && (row_r >= EDGE_MIN) && (col_r >= EDGE_MIN);
        last_pix_s = (row_r == wmax_s) && (col_r == wmax_s);
    end

    // Raster position counters and frame-mode latch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_r <= ZERO;
            col_r <= ZERO;
            st_r  <= 1'b0;
        end else if (clear) begin
            row_r <= ZERO;
            col_r <= ZERO;
        end else if (accept_s) begin
            if (first_s) begin
                st_r <= state;
            end
            if (col_r == wmax_s) begin
                col_r <= ZERO;
                row_r <= (row_r == wmax_s) ? ZERO : row_r + ONE;
            end else begin
                col_r <= col_r + ONE;
            end
        end
    end

    // Column-indexed line buffers (lb_r[0] is four rows back) and the sliding window.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < 4; i++) begin
                win_r[i][4] <= lb_r[i][col_r];
            end
            win_r[4][4] <= din;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    win_r[i][j] <= win_r[i][j+1];
                end
            end
            for (int k = 0; k < 3; k++) begin
                lb_r[k][col_r] <= lb_r[k+1][col_r];
            end
            lb_r[3][col_r] <= din;
        end
    end

    // Unsigned pixel times signed weight; both operands widened so the 17-bit product is exact.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                prod_s[i][j] = $signed({9'b0, win_r[i][j]}) *
                               $signed({{9{weights[8*(5*i+j)+7]}}, weights[8*(5*i+j) +: 8]});
            end
        end
    end

    // Five row sums of the registered products.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rsum_s[i] = {ACC_W{1'b0}};
            for (int j = 0; j < 5; j++) begin
                rsum_s[i] = rsum_s[i] + sext_prod(prod_r[i][j]);
            end
        end
    end

    // Final accumulation with sign-extended bias.
    always_comb begin
        acc_s = {{(ACC_W-20){bias[19]}}, bias};
        for (int i = 0; i < 5; i++) begin
            acc_s = acc_s + rsum_r[i];
        end
    end

    // ReLU, truncating shift, then clamp to 255.
    always_comb begin
        shifted_s = acc_r >>> shift;
        if (acc_r[ACC_W-1]) begin
            res_s = 8'd0;
        end else if (shifted_s > ACC_W'(255)) begin
            res_s = 8'd255;
        end else begin
            res_s = shifted_s[7:0];
        end
    end

    // Datapath stage registers; only the valid bits below need reset.
    always_ff @(posedge clk) begin
        prod_r <= prod_s;
        rsum_r <= rsum_s;
        acc_r  <= acc_s;
    end

    // Pipeline valid/last shift chain and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_r        <= 4'b0;
            last_r     <= 4'b0;
            ovalid     <= 1'b0;
            frame_done <= 1'b0;
            dout       <= 8'd0;
        end else if (clear) begin
            v_r        <= 4'b0;
            last_r     <= 4'b0;
            ovalid     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            v_r        <= {v_r[2:0], launch_s};
            last_r     <= {last_r[2:0], launch_s & last_pix_s};
            ovalid     <= v_r[3];
            frame_done <= v_r[3] & last_r[3];
            if (v_r[3]) begin
                dout <= res_s;
            end
        end
    end
endmodule

// File: tb/tb_conv5x5_window_relu.sv
// Scoreboard bench: a direct 2-D convolution model predicts every output pixel,
// its frame_done flag and its arrival time; a negedge monitor compares.
module tb_conv5x5_window_relu;
    logic         clk = 1'b0;
    logic         rstn;
    logic         state;
    logic         clear;
    logic         ivalid;
    logic [7:0]   din;
    logic [199:0] weights;
    logic [19:0]  bias;
    logic [4:0]   shift;
    logic         ovalid;
    logic [7:0]   dout;
    logic         frame_done;

    always #5 clk = ~clk;

    conv5x5_window_relu dut (
        .clk(clk), .rstn(rstn), .state(state), .clear(clear), .ivalid(ivalid),
        .din(din), .weights(weights), .bias(bias), .shift(shift),
        .ovalid(ovalid), .dout(dout), .frame_done(frame_done)
    );

    typedef struct {
        int     val;
        bit     fd;
        longint t;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   wv[25];
    int   bias_i;
    int   shift_i;
    int   img[28][28];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic set_params();
        for (int k = 0; k < 25; k++) weights[8*k +: 8] = wv[k][7:0];
        bias  = bias_i[19:0];
        shift = shift_i[4:0];
    endtask

    task automatic fill_w(input int v);
        for (int k = 0; k < 25; k++) wv[k] = v;
    endtask

    function automatic int model_out(input int r, input int c);
        int acc;
        int s;
        acc = bias_i;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                acc += img[r-4+i][c-4+j] * wv[5*i+j];
        if (acc < 0) return 0;
        s = acc >>> shift_i;
        return (s > 255) ? 255 : s;
    endfunction

    // Monitor: each ovalid pops one expectation; output must land 4 clocks after its launch edge.
    always @(negedge clk) begin
        exp_t e;
        if (frame_done && !ovalid) check("fd_without_ovalid", 1, 0);
        if (ovalid) begin
            if (q.size() == 0) begin
                check("unexpected_ovalid", 1, 0);
            end else begin
                e = q.pop_front();
                check("dout", dout, e.val);
                check("frame_done", frame_done, e.fd);
                check("latency", $time - 5, e.t);
            end
        end
    end

    task automatic accept_pixel(input int r, input int c, input int px, input int st_in, input bit fd);
        exp_t e;
        ivalid = 1'b1;
        din    = px[7:0];
        state  = st_in[0];
        @(posedge clk);
        img[r][c] = px;
        if (r >= 4 && c >= 4) begin
            e.val = model_out(r, c);
            e.fd  = fd;
            e.t   = $time + 40;
            q.push_back(e);
        end
        #1;
        ivalid = 1'b0;
        din    = 8'($urandom_range(0, 255));
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (8) idle_cycle();
        check("queue_drained", q.size(), 0);
    endtask

    // pat: 0 constant cval, 1 column index, 2 random. gapmode: 0 none, 1 alternate, 2 random.
    // abort_kind: 0 clear, 1 async reset, applied at (abort_row, 5); abort_row < 0 disables.
    task automatic run_frame(input int st, input int pat, input int cval, input int gapmode,
                             input int abort_row, input int abort_kind);
        int w;
        int px;
        int st_in;
        w = (st != 0) ? 12 : 28;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == abort_row && c == 5) begin
                    if (abort_kind == 0) begin
                        clear  = 1'b1;
                        ivalid = 1'b1;
                        @(posedge clk);
                        q.delete();
                        #1;
                        clear  = 1'b0;
                        ivalid = 1'b0;
                    end else begin
                        rstn = 1'b0;
                        q.delete();
                        #2;
                        check("rst_ovalid", ovalid, 0);
                        check("rst_dout", dout, 0);
                        check("rst_frame_done", frame_done, 0);
                        repeat (2) @(posedge clk);
                        #1;
                        rstn = 1'b1;
                    end
                    repeat (8) idle_cycle();
                    return;
                end
                if (gapmode == 1) idle_cycle();
                if (gapmode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
                st_in = (r == 0 && c == 0) ? st : int'($urandom_range(0, 1));
                px = (pat == 0) ? cval : (pat == 1) ? c : int'($urandom_range(0, 255));
                accept_pixel(r, c, px, st_in, (r == w-1) && (c == w-1));
            end
        end
    endtask

    initial begin
        rstn = 1'b0; state = 1'b0; clear = 1'b0; ivalid = 1'b0; din = 8'd0;
        weights = 200'd0; bias = 20'd0; shift = 5'd0;
        #2;
        check("reset_ovalid", ovalid, 0);
        check("reset_dout", dout, 0);
        check("reset_frame_done", frame_done, 0);
        #20;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        fill_w(1); bias_i = 0; shift_i = 0; set_params();
        run_frame(0, 0, 1, 0, -1, 0); drain();

        fill_w(127); bias_i = 0; shift_i = 0; set_params();
        run_frame(0, 0, 255, 0, -1, 0); drain();
        shift_i = 12; set_params();
        run_frame(0, 0, 255, 0, -1, 0); drain();

        fill_w(-1); bias_i = 100; shift_i = 0; set_params();
        run_frame(0, 0, 10, 0, -1, 0); drain();

        fill_w(0); wv[12] = 1; bias_i = 0; shift_i = 1; set_params();
        run_frame(0, 1, 0, 0, -1, 0); drain();

        fill_w(1); bias_i = -10; shift_i = 2; set_params();
        run_frame(1, 0, 2, 1, -1, 0); drain();

        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 25; k++) wv[k] = int'($urandom_range(0, 255)) - 128;
            bias_i  = int'($urandom_range(0, 40000)) - 20000;
            shift_i = int'($urandom_range(0, 10));
            set_params();
            run_frame(f % 2, 2, 0, 2, -1, 0); drain();
        end

        fill_w(1); bias_i = 0; shift_i = 0; set_params();
        run_frame(0, 2, 0, 0, 10, 0);
        run_frame(0, 0, 1, 0, -1, 0); drain();
        run_frame(0, 2, 0, 0, 10, 1);
        run_frame(0, 0, 1, 0, -1, 0); drain();
        run_frame(1, 2, 0, 2, -1, 0); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
